async_fifo_rd_stage: RTL and testbench

Read-side drain stage placed directly downstream of `async_fifo` in the `clk_r` domain. It pulls words from the FIFO's `rd_en`/`rdata` port, hides the FIFO's one-cycle read latency behind a 2-entry output buffer, and presents a valid/ready stream to the consumer. It marks burst boundaries and counts delivered words. It never reads an empty FIFO, so it cannot cause FIFO underflow.

---
 rtl/async_fifo_rd_stage.sv | 119 +++++++++++
 tb/tb_async_fifo_rd_stage.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_stage.sv
// Read-side drain stage for async_fifo: hides the FIFO's one-cycle read latency
// behind a 2-entry buffer and presents a valid/ready stream with burst markers.
module async_fifo_rd_stage #(
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic             clk_r,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_underflow,
  output logic             fifo_rd_en,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      word_cnt,
  output logic             err_underflow
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST - 1);

  logic [WIDTH-1:0] buf_q [2];
  logic [WIDTH-1:0] buf_d [2];
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q;
  logic [BW-1:0]    beat_q, beat_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             pop_s;
  logic [2:0]       level_s;
  logic [1:0]       tail_s;

  assign m_valid       = (occ_q != 2'd0);
  assign pop_s         = m_valid & m_ready;
  // Occupancy after this edge if nothing new is issued; combinational through
  // m_ready so a pop frees a slot in the same cycle and sustains 1 word/cycle.
  assign level_s       = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
  assign tail_s        = occ_q - {1'b0, pop_s};
  assign fifo_rd_en    = !rst && !fifo_empty && (level_s < 3'd2);
  assign m_data        = buf_q[0];
  assign m_last        = m_valid && (beat_q == BEAT_MAX);
  assign word_cnt      = cnt_q;
  assign err_underflow = err_q;

  // Next-state: head removal shifts slot 1 down, arriving data lands at the tail.
  always_comb begin
    buf_d  = buf_q;
    beat_d = beat_q;
    cnt_d  = cnt_q;
    occ_d  = level_s[1:0];
    err_d  = err_q | fifo_underflow;
    if (pop_s) begin
      buf_d[0] = buf_q[1];
      beat_d   = (beat_q == BEAT_MAX) ? '0 : beat_q + BW'(1);
      cnt_d    = cnt_q + 16'd1;
    end else begin
      beat_d   = beat_q;
      cnt_d    = cnt_q;
    end
    if (inflight_q) begin
      if (tail_s == 2'd0) begin
        buf_d[0] = fifo_rdata;
      end else begin
        buf_d[1] = fifo_rdata;
      end
    end else begin
      occ_d = level_s[1:0];
    end
  end

  // State registers; reset discards buffered and in-flight words immediately.
  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      cnt_q      <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  async_fifo_rd_stage_chk u_chk (
    .clk_r      (clk_r),
    .rst        (rst),
    .occ        (occ_q),
    .inflight   (inflight_q),
    .pop        (pop_s)
  );

endmodule

// Occupancy invariants of the drain stage.
module async_fifo_rd_stage_chk (
  input logic       clk_r,
  input logic       rst,
  input logic [1:0] occ,
  input logic       inflight,
  input logic       pop
);

  a_occ_bound: assert property (@(posedge clk_r) disable iff (rst)
    (({1'b0, occ} + {2'b00, inflight}) <= 3'd2));

  a_no_overfill: assert property (@(posedge clk_r) disable iff (rst)
    !(inflight && (occ == 2'd2) && !pop));

endmodule

// File: tb/tb_async_fifo_rd_stage.sv
// Directed bench for async_fifo_rd_stage with a behavioural FIFO read port.
module tb_async_fifo_rd_stage;

  logic        clk_r = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [15:0] fifo_rdata = 16'h0000;
  logic        fifo_underflow = 1'b0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;
  logic [15:0] word_cnt;
  logic        err_underflow;

  async_fifo_rd_stage #(.WIDTH(16), .BURST(4)) dut (
    .clk_r          (clk_r),
    .rst            (rst),
    .fifo_empty     (fifo_empty),
    .fifo_rdata     (fifo_rdata),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .word_cnt       (word_cnt),
    .err_underflow  (err_underflow)
  );

  always #5 clk_r = ~clk_r;

  logic [15:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk_r or posedge rst) begin
    if (rst) begin
      fifo_rdata <= 16'h0000;
    end else if (fifo_rd_en) begin
      fifo_rdata <= mem[rd_ptr[7:0]];
      rd_ptr     <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic        ready;
    logic        rd_en;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec [11];

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] got_data [$];
  logic        got_last [$];
  int rd_pulses, empty_viol, cyc, first_rd, first_valid, gap_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] gd(input int i);
    if (i < got_data.size()) return got_data[i];
    else return 16'hxxxx;
  endfunction

  function automatic logic gl(input int i);
    if (i < got_last.size()) return got_last[i];
    else return 1'bx;
  endfunction

  task automatic push(input logic [15:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr++;
  endtask

  task automatic clear_logs();
    got_data.delete();
    got_last.delete();
    rd_pulses   = 0;
    empty_viol  = 0;
    cyc         = 0;
    first_rd    = -1;
    first_valid = -1;
  endtask

  // Called #1 after a negedge, when this cycle's inputs and outputs are settled.
  task automatic sample();
    if (fifo_rd_en) begin
      rd_pulses++;
      if (first_rd < 0) first_rd = cyc;
    end
    if (fifo_rd_en && fifo_empty) empty_viol++;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
    end
    cyc++;
  endtask

  // mode 0: stalled, 1: always ready, 2: ready toggling 1,0,1,0...
  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_r);
      rst     = 1'b0;
      m_ready = (mode == 1) || (mode == 2 && (i % 2 == 0));
      #1;
      sample();
    end
  endtask

  task automatic reset_enter();
    @(negedge clk_r);
    rst     = 1'b1;
    m_ready = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    clear_logs();
    @(negedge clk_r);
  endtask

  initial begin
    vec[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    vec[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0};
    vec[2]  = '{1'b1, 1'b1, 1'b1, 16'hA001, 1'b0, 16'd0};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 16'hA002, 1'b0, 16'd1};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 16'hA002, 1'b0, 16'd1};
    vec[5]  = '{1'b0, 1'b0, 1'b1, 16'hA002, 1'b0, 16'd1};
    vec[6]  = '{1'b1, 1'b1, 1'b1, 16'hA002, 1'b0, 16'd1};
    vec[7]  = '{1'b1, 1'b1, 1'b1, 16'hA003, 1'b0, 16'd2};
    vec[8]  = '{1'b1, 1'b0, 1'b1, 16'hA004, 1'b1, 16'd3};
    vec[9]  = '{1'b1, 1'b0, 1'b1, 16'hA005, 1'b0, 16'd4};
    vec[10] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd5};
    clear_logs();

    // Reset state, with words already waiting in the FIFO.
    repeat (2) @(negedge clk_r);
    for (int i = 0; i < 5; i++) push(16'hA001 + 16'(i));
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_err", 32'(err_underflow), 32'd0);

    // Cycle-by-cycle vectors: issue, stall, resume and drain to empty.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_r);
      rst     = 1'b0;
      m_ready = vec[i].ready;
      #1;
      chk($sformatf("vec%0d_rd_en", i), 32'(fifo_rd_en), 32'(vec[i].rd_en));
      chk($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vec[i].valid));
      if (vec[i].valid) chk($sformatf("vec%0d_data", i), 32'(m_data), 32'(vec[i].data));
      chk($sformatf("vec%0d_last", i), 32'(m_last), 32'(vec[i].last));
      chk($sformatf("vec%0d_cnt", i), 32'(word_cnt), 32'(vec[i].cnt));
    end

    // 16 preloaded words at full throughput.
    reset_enter();
    for (int i = 0; i < 16; i++) push(16'h0001 + 16'(i));
    run(25, 1);
    chk("b_first_rd", 32'(first_rd), 32'd0);
    chk("b_latency", 32'(first_valid - first_rd), 32'd2);
    chk("b_count", 32'(got_data.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b_data%0d", i), 32'(gd(i)), 32'(16'h0001 + 16'(i)));
      chk($sformatf("b_last%0d", i), 32'(gl(i)), 32'((i % 4) == 3));
    end
    chk("b_word_cnt", 32'(word_cnt), 32'd16);
    chk("b_empty_viol", 32'(empty_viol), 32'd0);

    // Backpressure: 10 stalled cycles, then drain.
    reset_enter();
    for (int i = 0; i < 8; i++) push(16'h0C01 + 16'(i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_r);
      rst     = 1'b0;
      m_ready = 1'b0;
      #1;
      sample();
      if (i >= 2) chk($sformatf("c_hold%0d", i), 32'({m_valid, m_data}), 32'({1'b1, 16'h0C01}));
    end
    chk("c_stall_reads", 32'(rd_pulses), 32'd2);
    run(15, 1);
    chk("c_count", 32'(got_data.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("c_data%0d", i), 32'(gd(i)), 32'(16'h0C01 + 16'(i)));

    // Toggling ready.
    reset_enter();
    for (int i = 0; i < 12; i++) push(16'hD001 + 16'(i));
    run(40, 2);
    chk("d_count", 32'(got_data.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("d_data%0d", i), 32'(gd(i)), 32'(16'hD001 + 16'(i)));
    chk("d_word_cnt", 32'(word_cnt), 32'd12);

    // Writer gap: FIFO empty for 20 cycles between two groups of 3.
    reset_enter();
    for (int i = 0; i < 3; i++) push(16'hE001 + 16'(i));
    run(8, 1);
    gap_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_r);
      m_ready = 1'b1;
      #1;
      if (m_valid) gap_valid++;
      sample();
    end
    chk("e_gap_valid", 32'(gap_valid), 32'd0);
    @(negedge clk_r);
    for (int i = 0; i < 3; i++) push(16'hE004 + 16'(i));
    #1;
    chk("e_resume", 32'(fifo_rd_en), 32'd1);
    sample();
    run(10, 1);
    chk("e_count", 32'(got_data.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("e_data%0d", i), 32'(gd(i)), 32'(16'hE001 + 16'(i)));
      chk($sformatf("e_last%0d", i), 32'(gl(i)), 32'(i == 3));
    end
    chk("e_empty_viol", 32'(empty_viol), 32'd0);

    // Reset asserted with a word buffered and one in flight.
    reset_enter();
    for (int i = 0; i < 6; i++) push(16'hF001 + 16'(i));
    run(3, 1);
    @(negedge clk_r);
    m_ready = 1'b0;
    #1;
    chk("f_pre_state", 32'({m_valid, m_data, word_cnt}), 32'({1'b1, 16'hF002, 16'd1}));
    rst = 1'b1;
    #1;
    chk("f_rst_valid", 32'(m_valid), 32'd0);
    chk("f_rst_data", 32'(m_data), 32'd0);
    chk("f_rst_last", 32'(m_last), 32'd0);
    chk("f_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("f_rst_cnt", 32'(word_cnt), 32'd0);
    wr_ptr = rd_ptr;
    clear_logs();
    @(negedge clk_r);
    for (int i = 0; i < 4; i++) push(16'hF101 + 16'(i));
    run(12, 1);
    chk("f_count", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("f_data%0d", i), 32'(gd(i)), 32'(16'hF101 + 16'(i)));
    chk("f_last3", 32'(gl(3)), 32'd1);
    chk("f_word_cnt", 32'(word_cnt), 32'd4);

    // Sticky underflow error.
    chk("g_err_before", 32'(err_underflow), 32'd0);
    @(negedge clk_r);
    fifo_underflow = 1'b1;
    @(negedge clk_r);
    fifo_underflow = 1'b0;
    #1;
    chk("g_err_set", 32'(err_underflow), 32'd1);
    run(5, 1);
    chk("g_err_sticky", 32'(err_underflow), 32'd1);
    reset_enter();
    #1;
    chk("g_err_cleared", 32'(err_underflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
